// File: rtl/evt_pulse_gen.sv
// Programmable event-strobe generator: periodic one-cycle evt_out pulses, finite or continuous.
// Optional mid-run restart on start_in is enabled by defining EVT_PULSE_GEN_RETRIGGER_EN.
module evt_pulse_gen #(
  parameter int PERIOD_WIDTH = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  input  logic [COUNT_WIDTH-1:0]  num_pulses_in,
  output logic                    evt_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [COUNT_WIDTH-1:0]  pulse_count_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
  logic [COUNT_WIDTH-1:0]  remain_q, remain_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    evt_q, evt_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    load;
  logic [PERIOD_WIDTH-1:0] period_eff;

  assign period_eff = (period_in == '0) ? PERIOD_WIDTH'(1) : period_in;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    count_d  = count_q;
    evt_d    = 1'b0;
    last_d   = 1'b0;
    done_d   = last_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in && !stop_in) load = 1'b1;
      end
      RUN: begin
        if (stop_in) begin
          state_d = IDLE;
`ifdef EVT_PULSE_GEN_RETRIGGER_EN
        end else if (start_in) begin
          load = 1'b1;
`endif
        end else if (phase_q == period_q - PERIOD_WIDTH'(1)) begin
          phase_d = '0;
          evt_d   = 1'b1;
          count_d = count_q + COUNT_WIDTH'(1);
          // A remaining count of zero while running can only mean continuous mode.
          if (remain_q != '0) begin
            remain_d = remain_q - COUNT_WIDTH'(1);
            if (remain_q == COUNT_WIDTH'(1)) begin
              state_d = IDLE;
              last_d  = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q + PERIOD_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = RUN;
      period_d = period_eff;
      remain_d = num_pulses_in;
      phase_d  = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      period_q <= '0;
      phase_q  <= '0;
      remain_q <= '0;
      count_q  <= '0;
      evt_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      evt_q    <= evt_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign evt_out         = evt_q;
  assign busy_out        = (state_q == RUN);
  assign done_out        = done_q;
  assign pulse_count_out = count_q;

endmodule

// File: tb/tb_evt_pulse_gen.sv
// Scoreboard bench for evt_pulse_gen: expected pulses/done are queued by the stimulus,
// a negedge monitor pops and compares whenever the DUT raises evt_out or done_out.
module tb_evt_pulse_gen;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic [15:0] period_in = '0;
  logic [15:0] num_pulses_in = '0;
  logic        evt_out;
  logic        busy_out;
  logic        done_out;
  logic [15:0] pulse_count_out;

  evt_pulse_gen #(.PERIOD_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .stop_in         (stop_in),
    .period_in       (period_in),
    .num_pulses_in   (num_pulses_in),
    .evt_out         (evt_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .pulse_count_out (pulse_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int c;
    int n;
  } evt_t;

  evt_t exp_evt[$];
  int   exp_done[$];
  int   total = 0;
  int   bad = 0;

  // Monitor: cycle index is the edge number after which the output is visible.
  always @(negedge clk_in) begin
    evt_t e;
    int   d;
    while (exp_evt.size() > 0 && exp_evt[0].c < cyc) begin
      e = exp_evt.pop_front();
      total++; bad++;
      $display("FAIL evt_missing actual=none required=evt@%0d cnt=%0d", e.c, e.n);
    end
    while (exp_done.size() > 0 && exp_done[0] < cyc) begin
      d = exp_done.pop_front();
      total++; bad++;
      $display("FAIL done_missing actual=none required=done@%0d", d);
    end
    if (evt_out === 1'b1) begin
      total++;
      if (exp_evt.size() > 0 && exp_evt[0].c == cyc) begin
        e = exp_evt.pop_front();
        if (pulse_count_out !== 16'(e.n)) begin
          bad++;
          $display("FAIL evt_count@%0d actual=%0d required=%0d", cyc, pulse_count_out, 16'(e.n));
        end else
          $display("evt  @%0d cnt=%0d ok", cyc, pulse_count_out);
      end else begin
        bad++;
        $display("FAIL evt_unexpected@%0d actual=1 required=0", cyc);
      end
    end
    if (done_out === 1'b1) begin
      total++;
      if (exp_done.size() > 0 && exp_done[0] == cyc) begin
        d = exp_done.pop_front();
        $display("done @%0d ok", d);
      end else begin
        bad++;
        $display("FAIL done_unexpected@%0d actual=1 required=0", cyc);
      end
    end
  end

  task automatic step(int k = 1);
    repeat (k) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic step_to(int c);
    while (cyc < c) step();
  endtask

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s@%0d actual=%0d required=%0d", name, cyc, act, req);
    end else
      $display("chk  %s@%0d = %0d ok", name, cyc, act);
  endtask

  task automatic start_run(int p, int n, output int t);
    start_in      = 1'b1;
    period_in     = 16'(p);
    num_pulses_in = 16'(n);
    step();
    start_in = 1'b0;
    t = cyc;
  endtask

  task automatic push_evt(int c, int n);
    evt_t e;
    e.c = c;
    e.n = n & 16'hFFFF;
    exp_evt.push_back(e);
  endtask

  task automatic push_train(int t, int p, int n);
    int pe;
    pe = (p == 0) ? 1 : p;
    for (int k = 1; k <= n; k++) push_evt(t + k * pe, k);
    exp_done.push_back(t + n * pe + 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_evt"}, int'(evt_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
    chk({tag, "_done"}, int'(done_out), 0);
    chk({tag, "_count"}, int'(pulse_count_out), 0);
  endtask

  initial begin
    int t, t2, r;
    // Reset state
    step(3);
    chk_all_zero("reset");
    rst_in = 1'b0;
    step();

    // Basic finite run: period 4, count 3
    start_run(4, 3, t);
    push_train(t, 4, 3);
    chk("run1_busy_start", int'(busy_out), 1);
    step_to(t + 11);
    chk("run1_busy_before_last", int'(busy_out), 1);
    step();
    chk("run1_busy_at_last", int'(busy_out), 0);
    chk("run1_count", int'(pulse_count_out), 3);

    // Back-to-back: start accepted in the done cycle
    start_run(2, 2, t2);
    push_train(t2, 2, 2);
    chk("b2b_busy", int'(busy_out), 1);
    chk("b2b_done_high", int'(done_out), 1);
    step_to(t2 + 6);
    chk("b2b_busy_end", int'(busy_out), 0);
    chk("b2b_count", int'(pulse_count_out), 2);

    // Start and stop together in IDLE
    start_in = 1'b1; stop_in = 1'b1; period_in = 16'd7; num_pulses_in = 16'd1;
    step();
    start_in = 1'b0; stop_in = 1'b0;
    chk("idle_ss_busy", int'(busy_out), 0);
    chk("idle_ss_count", int'(pulse_count_out), 2);
    step(10);
    chk("idle_ss_busy_later", int'(busy_out), 0);

    // Stop exactly when pulse 2 is due
    start_run(5, 10, t);
    push_evt(t + 5, 1);
    step_to(t + 9);
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    chk("stop_busy", int'(busy_out), 0);
    chk("stop_count", int'(pulse_count_out), 1);
    step(8);
    chk("stop_busy_later", int'(busy_out), 0);
    chk("stop_count_later", int'(pulse_count_out), 1);

    // Mid-run start with a different period
    start_run(3, 4, t);
    push_evt(t + 3, 1);
    step_to(t + 4);
    start_run(2, 4, r);
`ifdef EVT_PULSE_GEN_RETRIGGER_EN
    push_train(r, 2, 4);
`else
    push_evt(t + 6, 2);
    push_evt(t + 9, 3);
    push_evt(t + 12, 4);
    exp_done.push_back(t + 13);
`endif
    step(14);
    chk("midstart_busy_end", int'(busy_out), 0);
    chk("midstart_count", int'(pulse_count_out), 4);

    // Mid-run reset, then a fresh run
    start_run(4, 5, t);
    push_evt(t + 4, 1);
    step_to(t + 6);
    rst_in = 1'b1;
    step();
    chk_all_zero("midreset");
    rst_in = 1'b0;
    start_run(2, 1, t);
    push_train(t, 2, 1);
    step(4);
    chk("postreset_busy", int'(busy_out), 0);
    chk("postreset_count", int'(pulse_count_out), 1);

    // Continuous mode with period 0: every cycle, count wraps, then stop
    start_run(0, 0, t);
    for (int k = 1; k <= 65537; k++) push_evt(t + k, k);
    step_to(t + 65535);
    chk("cont_count_max", int'(pulse_count_out), 65535);
    step();
    chk("cont_count_wrap", int'(pulse_count_out), 0);
    chk("cont_busy", int'(busy_out), 1);
    step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    chk("cont_stop_busy", int'(busy_out), 0);
    chk("cont_stop_count", int'(pulse_count_out), 1);
    step(5);

    chk("evt_queue_left", exp_evt.size(), 0);
    chk("done_queue_left", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/evt_pulse_gen.md
# evt_pulse_gen

Programmable event-strobe generator: after a start request it emits single-cycle `evt_out` pulses at a fixed period for a requested number of pulses, or continuously, then signals completion. It is the producer side of the event-counting path. Game timing logic uses it to drive event-counter inputs such as round ticks and countdown beats at controlled rates. The block is fully synchronous and sits in the game-logic clock domain.

## Interface
- `PERIOD_WIDTH`, 16: width of `period_in` and of the internal phase counter.
- `COUNT_WIDTH`, 16: width of `num_pulses_in` and `pulse_count_out`.

- `clk_in` input 1: system clock; all state is updated on its rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `start_in` input 1: start request, sampled each cycle.
- `stop_in` input 1: abort request, sampled each cycle.
- `period_in` input PERIOD_WIDTH: cycles between pulses; latched on an accepted start. A value of 0 is treated as 1.
- `num_pulses_in` input COUNT_WIDTH: pulses to emit; latched on an accepted start. A value of 0 means continuous.
- `evt_out` output 1: event strobe, one cycle wide.
- `busy_out` output 1: high while a run is active.
- `done_out` output 1: one-cycle pulse when a finite run completes.
- `pulse_count_out` output COUNT_WIDTH: pulses emitted in the current or most recent run.

## Operation
- States:
  - IDLE: reset state.
  - RUN: a pulse train is in progress.
- Reset, when `rst_in` is high at an edge:
  - State goes to IDLE.
  - `evt_out`, `busy_out`, `done_out` are 0.
  - `pulse_count_out`, the phase counter and the remaining-pulse counter are 0.
  - Reset overrides every other input.
- IDLE, `start_in`=1 and `stop_in`=0:
  - Latch the period, with 0 mapped to 1, and latch `num_pulses_in`.
  - Clear the phase counter and `pulse_count_out`.
  - Go to RUN with `busy_out`=1.
- IDLE, `start_in`=1 and `stop_in`=1: stop wins; the block stays in IDLE.
- RUN counting:
  - The phase counter counts 0 to P-1, where P is the latched period.
  - When it reaches P-1 it wraps to 0, `evt_out` is 1 for that cycle, and `pulse_count_out` increments.
- RUN, finite count N:
  - The edge that produces pulse N also moves the state to IDLE and clears `busy_out`.
  - `done_out` is 1 in the cycle after the final `evt_out`.
- RUN, continuous mode (N=0):
  - The train never self-terminates.
  - `pulse_count_out` wraps from 2^COUNT_WIDTH-1 to 0.
  - `done_out` is never asserted.
- RUN, `stop_in`=1:
  - Go to IDLE on the next edge with `busy_out`=0.
  - No `evt_out` is emitted at that edge, even if a pulse was due; stop has priority.
  - No `done_out` is produced.
  - `pulse_count_out` holds its value.
- RUN, `start_in` without `stop_in`: see Configuration.
- Changes to `period_in` or `num_pulses_in` during RUN are ignored.
- In IDLE, `pulse_count_out` holds the last run's total until the next accepted start.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start accepted at edge T:
  - `busy_out`=1 from T.
  - First `evt_out` in the cycle following edge T+P.
  - Subsequent pulses every P cycles.
- P=1 gives `evt_out` high every cycle for N consecutive cycles.
- `pulse_count_out` updates at the same edge that raises `evt_out`.
- Finite run with last pulse at edge E:
  - `busy_out`=0 from edge E.
  - `done_out`=1 for exactly one cycle from edge E+1.
- A new start is accepted at edge E+1, i.e. while `done_out` is high. `done_out` still pulses.
- Throughput: one run may start the cycle after the previous one ends.

## Configuration
- `EVT_PULSE_GEN_RETRIGGER_EN` defined:
  - `start_in`=1 with `stop_in`=0 in RUN restarts the run.
  - It relatches `period_in` and `num_pulses_in` and clears the phase counter and `pulse_count_out`.
  - There is no `evt_out` at that edge and no `done_out`.
  - The first pulse of the new run follows P new cycles later.
- Not defined: `start_in` in RUN is ignored entirely.

## Test plan
- Basic finite run:
  - Stimulus: reset, then start with period 4, count 3.
  - Required: `evt_out` at cycles T+4, T+8, T+12 after the start edge; `pulse_count_out` ends at 3.
  - Required: `busy_out` falls with the third pulse; `done_out` is one cycle long immediately after it.
- Degenerate period with zero-count start:
  - Stimulus: period 0, count 0.
  - Required: `evt_out` high every cycle; `pulse_count_out` wraps from 65535 to 0; `done_out` never asserts.
  - Stimulus: `stop_in` asserted.
  - Required: `busy_out`=0 on the next edge with no `done_out`.
- Stop on a due pulse:
  - Stimulus: period 5, count 10; `stop_in` asserted at the edge where pulse 2 is due.
  - Required: no `evt_out`; `pulse_count_out` holds at 1; state returns to IDLE.
- Mid-run start:
  - Stimulus: period 3, count 4; `start_in` with period 2 during RUN.
  - Required, macro undefined: start is ignored and 4 pulses are emitted at period 3.
  - Required, macro defined: the run restarts and emits 4 pulses at period 2 from the restart edge.
- Mid-run reset:
  - Stimulus: `rst_in` asserted mid-run.
  - Required: all outputs 0 at the next edge; a subsequent start behaves as from power-up.
- Back-to-back runs and start/stop in IDLE:
  - Stimulus: start a new run in the cycle `done_out` is high.
  - Required: accepted; the first pulse arrives P cycles later.
  - Stimulus: `start_in` and `stop_in` together in IDLE.
  - Required: the block stays in IDLE.
